wr_frontend: RTL and testbench
==============================

// Module: wr_frontend
// PURPOSE
//  Write-domain front end of the async FIFO. It sits directly upstream of the write-pointer/full block.
//  - Accepts producer data on a valid/ready handshake into a 2-entry skid buffer.
//  - Drives the write-pointer block's write enable and the write data.
//  - Synchronises the read domain's Gray read pointer into the write clock, converts it to binary, and
//    feeds the result to the write-pointer block for its full compare.
//  - Reports fill level and almost-full from the resulting pointer difference.
// PARAMETERS
//  PTR_WIDTH    3   address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits
//  DATA_WIDTH   8   width of a FIFO word
//  SYNC_STAGES  2   flop stages on the Gray read pointer; legal values are >= 2
//  AF_MARGIN    1   o_almost_full asserts when level >= 2**PTR_WIDTH - AF_MARGIN
// PORTS
//  i_wr_clk       in   1             write clock; the only clock in the block
//  i_rst          in   1             synchronous reset, active high
//  i_s_valid      in   1             producer word valid
//  i_s_data       in   DATA_WIDTH    producer word
//  o_s_ready      out  1             skid buffer can take a word this cycle
//  i_rdptr_gray   in   PTR_WIDTH+1   Gray read pointer from the read clock domain (asynchronous)
//  i_wrptr        in   PTR_WIDTH+1   binary write pointer from the write-pointer block
//  i_full_flag    in   1             full flag from the write-pointer block
//  o_wr_en        out  1             write enable to the write-pointer block and to the memory
//  o_wr_data      out  DATA_WIDTH    word to write; valid when o_wr_en = 1
//  o_rdptr_sync   out  PTR_WIDTH+1   synchronised binary read pointer
//  o_level        out  PTR_WIDTH+1   words in the FIFO as seen from the write side
//  o_almost_full  out  1             o_level >= 2**PTR_WIDTH - AF_MARGIN
//  o_wr_count     out  16            count of words committed (o_wr_en = 1); wraps modulo 2**16
// BEHAVIOUR
//  Reset (i_rst = 1 at a clock edge): the following all go to 0 —
//   skid count, both skid entries, all sync stages, o_rdptr_sync, o_wr_count.
//   o_s_ready is forced to 0 in every cycle where i_rst = 1.
//   Reset mid-transfer discards any buffered words; no o_wr_en is issued for them.
//  Skid buffer: states EMPTY(0), ONE(1), TWO(2); entries are kept in FIFO order (head = oldest).
//   accept = i_s_valid & o_s_ready
//   pop    = o_wr_en = (state != EMPTY) & !i_full_flag
//   o_wr_data = head entry, a direct register output
//   o_s_ready = !i_rst & (state != TWO); depends on registered state only
//   Next state = state + accept - pop.
//   Simultaneous accept and pop in ONE: new word moves to the head; state stays ONE.
//   Simultaneous accept and pop in TWO: cannot occur, because ready = 0 in TWO.
//   While i_full_flag = 1, no pop occurs; buffered words hold and are never overwritten or dropped.
//   o_wr_en is never asserted while i_full_flag = 1.
//  Latency: a word accepted at edge N reaches o_wr_en at edge N+1 at the earliest (not full).
//   With i_s_valid held high and the FIFO not full, throughput is 1 word per cycle.
//  Synchroniser: i_rdptr_gray is sampled through SYNC_STAGES flops; only the first stage sees async data.
//   Gray-to-binary conversion is done on the last stage:
//     b[PTR_WIDTH] = g[PTR_WIDTH]
//     b[k] = b[k+1] ^ g[k]
//   The converted value is registered into o_rdptr_sync.
//   Total delay from i_rdptr_gray to o_rdptr_sync is SYNC_STAGES+1 edges.
//  Level: o_level = (i_wrptr - o_rdptr_sync) modulo 2**(PTR_WIDTH+1); combinational.
//   This is correct across pointer wrap.
//   Range is 0..2**PTR_WIDTH; the value 2**PTR_WIDTH coincides with i_full_flag = 1.
//   Because the read pointer lags, the level is conservative: it may over-read, never under-read.
//  o_wr_count increments on every cycle where o_wr_en = 1 and wraps from 0xFFFF to 0.
// TESTING
//  1. Reset: assert i_rst for 2 cycles with i_s_valid = 1 ->
//     o_s_ready = 0, o_wr_en = 0, o_rdptr_sync = 0, o_wr_count = 0.
//  2. Streaming: PTR_WIDTH = 3, read side stalled, 8 words 0x01..0x08 with valid held ->
//     o_wr_en on 8 consecutive cycles in order; i_full_flag = 1 after word 8;
//     o_almost_full rises at level 7.
//  3. Backpressure: full FIFO, offer 0xA1, 0xA2, 0xA3 ->
//     0xA1 and 0xA2 are held, o_s_ready = 0; no o_wr_en while full;
//     after the read pointer advances by 2, 0xA1 then 0xA2 are written.
//  4. Sync latency: step i_rdptr_gray from 4'b0000 to 4'b0001 ->
//     o_rdptr_sync = 1 exactly SYNC_STAGES+1 edges later.
//     Gray 4'b1100 maps to binary 8 (wrap bit set).
//  5. Wrap: drive the pointers through 15 -> 0 with i_wrptr = 2 and read pointer = 14 ->
//     o_level = 4, and no spurious full.
//  6. Reset mid-operation: i_rst pulsed with state = TWO ->
//     buffer empties, no write is issued for the dropped words, o_s_ready returns 1 the cycle after reset.

Source files
------------

// File: rtl/wr_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : wr_frontend_if
//  Description : Bus bundle between the write-domain front end and its
//                environment: producer valid/ready handshake, the
//                write-pointer block connection and the status outputs.
//                slave  - the front end itself
//                master - producer / write-pointer block / testbench side
//  Ports       : i_s_valid, i_s_data, o_s_ready   producer handshake
//                i_rdptr_gray                     async Gray read pointer
//                i_wrptr, i_full_flag             from write-pointer block
//                o_wr_en, o_wr_data               to write-pointer block/memory
//                o_rdptr_sync, o_level,
//                o_almost_full, o_wr_count        status
//  Revision    : 1.0 - initial release
// ============================================================================
interface wr_frontend_if #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  i_s_valid;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  o_s_ready;
    logic [PTR_WIDTH:0]    i_rdptr_gray;
    logic [PTR_WIDTH:0]    i_wrptr;
    logic                  i_full_flag;
    logic                  o_wr_en;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic [PTR_WIDTH:0]    o_rdptr_sync;
    logic [PTR_WIDTH:0]    o_level;
    logic                  o_almost_full;
    logic [15:0]           o_wr_count;

    modport slave (
        input  i_s_valid, i_s_data, i_rdptr_gray, i_wrptr, i_full_flag,
        output o_s_ready, o_wr_en, o_wr_data, o_rdptr_sync, o_level,
               o_almost_full, o_wr_count
    );

    modport master (
        output i_s_valid, i_s_data, i_rdptr_gray, i_wrptr, i_full_flag,
        input  o_s_ready, o_wr_en, o_wr_data, o_rdptr_sync, o_level,
               o_almost_full, o_wr_count
    );
endinterface
`default_nettype wire

// File: rtl/wr_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : wr_frontend
//  Description : Write-domain front end of the async FIFO.
//                - 2-entry skid buffer on the producer valid/ready handshake
//                - drives write enable / write data to the write-pointer block
//                - synchronises the Gray read pointer into the write clock,
//                  converts it to binary and registers it (o_rdptr_sync)
//                - reports fill level and almost-full from the pointer gap
//  Ports       : i_wr_clk  write clock (only clock in the block)
//                i_rst     synchronous reset, active high
//                bus       wr_frontend_if.slave (handshake, pointer and
//                          status signals)
//  Parameters  : PTR_WIDTH   address bits (pointers are PTR_WIDTH+1 bits)
//                DATA_WIDTH  FIFO word width
//                SYNC_STAGES Gray pointer synchroniser depth, must be >= 2
//                AF_MARGIN   almost-full when level >= 2**PTR_WIDTH - AF_MARGIN
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_frontend #(
    parameter int PTR_WIDTH   = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 1
) (
    input  wire logic          i_wr_clk,
    input  wire logic          i_rst,
    wr_frontend_if.slave       bus
);

    localparam logic [PTR_WIDTH:0] c_af_threshold =
        (PTR_WIDTH+1)'((1 << PTR_WIDTH) - AF_MARGIN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_pop;

    // Ready is a function of registered state (and reset) only, so there is
    // no combinational path from i_full_flag back to the producer.
    assign w_ready  = !i_rst && (r_state != ST_TWO);
    assign w_accept = bus.i_s_valid && w_ready;
    assign w_pop    = (r_state != ST_EMPTY) && !bus.i_full_flag;

    always_ff @(posedge i_wr_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = bus.i_s_data;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    // Head leaves, the new word takes its place.
                    w_head_nxt = bus.i_s_data;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_tail_nxt  = bus.i_s_data;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // No accept possible here: ready is low in TWO.
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Committed-word counter (wraps naturally at 16 bits)
    // ------------------------------------------------------------------
    logic [15:0] r_wr_count;

    always_ff @(posedge i_wr_clk) begin
        if (i_rst) begin
            r_wr_count <= '0;
        end else if (w_pop) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read-pointer synchroniser. Only stage 0 sees asynchronous data; the
    // Gray-to-binary conversion is done on the last (settled) stage and the
    // result registered so the downstream full compare sees a clean value.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][PTR_WIDTH:0] r_sync;
    logic [PTR_WIDTH:0]                  w_gray_last;
    logic [PTR_WIDTH:0]                  w_rd_bin;
    logic [PTR_WIDTH:0]                  r_rdptr_sync;

    always_ff @(posedge i_wr_clk) begin
        if (i_rst) begin
            r_sync       <= '0;
            r_rdptr_sync <= '0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.i_rdptr_gray};
            r_rdptr_sync <= w_rd_bin;
        end
    end

    assign w_gray_last = r_sync[SYNC_STAGES-1];

    // b[k] = XOR of Gray bits k..MSB, equivalent to b[k] = b[k+1] ^ g[k].
    always_comb begin
        w_rd_bin = '0;
        for (int k = 0; k <= PTR_WIDTH; k++) begin
            w_rd_bin[k] = ^(w_gray_last >> k);
        end
    end

    // ------------------------------------------------------------------
    // Level: modular difference handles pointer wrap. The read pointer
    // lags, so this can only over-report the fill.
    // ------------------------------------------------------------------
    logic [PTR_WIDTH:0] w_level;

    assign w_level = bus.i_wrptr - r_rdptr_sync;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_s_ready     = w_ready;
    assign bus.o_wr_en       = w_pop;
    assign bus.o_wr_data     = r_head;
    assign bus.o_rdptr_sync  = r_rdptr_sync;
    assign bus.o_level       = w_level;
    assign bus.o_almost_full = (w_level >= c_af_threshold);
    assign bus.o_wr_count    = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_wr_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wr_frontend
//  Description : Directed self-checking bench for wr_frontend. Models the
//                write-pointer block (pointer counter + full flag) and the
//                read side (binary read pointer driven as Gray code).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_frontend;

    logic clk;
    logic rst;

    wr_frontend_if #(.PTR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    wr_frontend #(
        .PTR_WIDTH  (3),
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .AF_MARGIN  (1)
    ) u_dut (
        .i_wr_clk(clk),
        .i_rst   (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write-pointer block model and read side
    logic [3:0] wr_cnt = 4'd0;   // words committed (mod 16)
    logic [3:0] wp_ofs;          // lets the bench relocate the write pointer
    logic [3:0] rd_ptr;          // binary read pointer (read domain)
    logic       full;
    logic [7:0] wr_log[$];

    assign bus.i_wrptr      = wr_cnt + wp_ofs;
    assign full             = ((bus.i_wrptr - rd_ptr) == 4'd8);
    assign bus.i_full_flag  = full;
    assign bus.i_rdptr_gray = rd_ptr ^ (rd_ptr >> 1);

    always @(posedge clk) begin
        if (bus.o_wr_en === 1'b1) begin
            wr_log.push_back(bus.o_wr_data);
            wr_cnt <= wr_cnt + 4'd1;
            check("wr_en_while_full", {31'd0, full}, 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 8'h55;
        rd_ptr        = 4'd0;
        wp_ofs        = 4'd0;

        // ---- 1. Reset with valid held high ----
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready",   {31'd0, bus.o_s_ready}, 32'd0);
            check("rst_wr_en",   {31'd0, bus.o_wr_en},   32'd0);
            check("rst_rdsync",  {28'd0, bus.o_rdptr_sync}, 32'd0);
            check("rst_wrcount", {16'd0, bus.o_wr_count},   32'd0);
        end
        rst           = 1'b0;
        bus.i_s_valid = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, bus.o_s_ready}, 32'd1);
        check("post_rst_wr_en", {31'd0, bus.o_wr_en},   32'd0);

        // ---- 4. Synchroniser latency (3 edges) and Gray decode ----
        rd_ptr = 4'd1;
        tick(); check("sync_lat_e1", {28'd0, bus.o_rdptr_sync}, 32'd0);
        tick(); check("sync_lat_e2", {28'd0, bus.o_rdptr_sync}, 32'd0);
        tick(); check("sync_lat_e3", {28'd0, bus.o_rdptr_sync}, 32'd1);
        rd_ptr = 4'd8;               // Gray 4'b1100
        repeat (3) tick();
        check("gray_1100_bin", {28'd0, bus.o_rdptr_sync}, 32'd8);
        check("gray_1100_lvl", {28'd0, bus.o_level},      32'd8);
        rd_ptr = 4'd0;
        repeat (3) tick();
        check("sync_back_0", {28'd0, bus.o_rdptr_sync}, 32'd0);

        // ---- 2. Streaming 8 words, read side stalled ----
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("stream_wr_en_%0d", k), {31'd0, bus.o_wr_en}, 32'd1);
            check($sformatf("stream_data_%0d", k),  {24'd0, bus.o_wr_data}, k);
            check($sformatf("stream_lvl_%0d", k),   {28'd0, bus.o_level}, k - 1);
            check($sformatf("stream_af_%0d", k),    {31'd0, bus.o_almost_full}, (k == 8) ? 32'd1 : 32'd0);
            if (k < 8) bus.i_s_data = 8'(k + 1);
            else       bus.i_s_valid = 1'b0;
        end
        tick();
        check("full_after_8", {31'd0, full},              32'd1);
        check("full_level",   {28'd0, bus.o_level},       32'd8);
        check("full_af",      {31'd0, bus.o_almost_full}, 32'd1);
        check("full_wr_en",   {31'd0, bus.o_wr_en},       32'd0);
        check("stream_count", wr_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wr_log.size())
                check($sformatf("stream_log_%0d", i), {24'd0, wr_log[i]}, i + 1);
        end

        // ---- 3. Backpressure while full ----
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 8'hA1;
        tick();
        check("bp_ready_one", {31'd0, bus.o_s_ready}, 32'd1);
        check("bp_wr_en_one", {31'd0, bus.o_wr_en},   32'd0);
        bus.i_s_data = 8'hA2;
        tick();
        bus.i_s_data = 8'hA3;
        for (int i = 0; i < 4; i++) begin
            check("bp_ready_two", {31'd0, bus.o_s_ready}, 32'd0);
            check("bp_wr_en_two", {31'd0, bus.o_wr_en},   32'd0);
            check("bp_head",      {24'd0, bus.o_wr_data}, 32'hA1);
            tick();
        end
        rd_ptr = 4'd2;               // reader frees two slots
        tick();
        check("bp_rel_wr_en", {31'd0, bus.o_wr_en},   32'd1);
        check("bp_rel_data",  {24'd0, bus.o_wr_data}, 32'hA2);
        check("bp_rel_ready", {31'd0, bus.o_s_ready}, 32'd1);
        tick();
        check("bp_refull_wr_en", {31'd0, bus.o_wr_en},   32'd0);
        check("bp_a3_head",      {24'd0, bus.o_wr_data}, 32'hA3);
        bus.i_s_valid = 1'b0;
        check("bp_count", wr_log.size(), 32'd10);
        if (wr_log.size() >= 10) begin
            check("bp_log_a1", {24'd0, wr_log[8]}, 32'hA1);
            check("bp_log_a2", {24'd0, wr_log[9]}, 32'hA2);
        end
        rd_ptr = 4'd10;              // drain
        tick();
        check("drain_count", wr_log.size(), 32'd11);
        if (wr_log.size() >= 11)
            check("drain_log_a3", {24'd0, wr_log[10]}, 32'hA3);
        check("drain_wrcount", {16'd0, bus.o_wr_count}, 32'd11);
        repeat (2) tick();
        check("drain_rdsync", {28'd0, bus.o_rdptr_sync}, 32'd10);
        check("drain_level",  {28'd0, bus.o_level},      32'd1);
        check("drain_af",     {31'd0, bus.o_almost_full}, 32'd0);

        // ---- 5. Wrap: write pointer 2, read pointer 14 ----
        wp_ofs = 4'd7;               // 11 committed + 7 = 2 (mod 16)
        rd_ptr = 4'd14;
        repeat (3) tick();
        check("wrap_rdsync", {28'd0, bus.o_rdptr_sync}, 32'd14);
        check("wrap_level",  {28'd0, bus.o_level},      32'd4);
        check("wrap_af",     {31'd0, bus.o_almost_full}, 32'd0);
        check("wrap_full",   {31'd0, full},             32'd0);

        // ---- 6. Reset with two words buffered ----
        rd_ptr        = 4'd10;       // 2 - 10 = 8 -> full
        bus.i_s_valid = 1'b1;
        bus.i_s_data  = 8'hB1;
        tick();
        bus.i_s_data = 8'hB2;
        tick();
        check("mid_ready_two", {31'd0, bus.o_s_ready}, 32'd0);
        check("mid_head",      {24'd0, bus.o_wr_data}, 32'hB1);
        rst          = 1'b1;
        bus.i_s_data = 8'hB3;
        tick();
        check("mid_rst_ready", {31'd0, bus.o_s_ready}, 32'd0);
        rst           = 1'b0;
        bus.i_s_valid = 1'b0;
        rd_ptr        = 4'd2;        // not full: any leftover word would pop
        tick();
        check("mid_ready_back", {31'd0, bus.o_s_ready}, 32'd1);
        check("mid_wr_en_0",    {31'd0, bus.o_wr_en},   32'd0);
        check("mid_wrcount",    {16'd0, bus.o_wr_count}, 32'd0);
        tick();
        check("mid_wr_en_1",    {31'd0, bus.o_wr_en},   32'd0);
        check("mid_log_count",  wr_log.size(), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
